// File: rtl/rv_i2c_pkg.sv
// Shared types for the byte-level I2C command/response channel and its arbiter.
package rv_i2c_pkg;

    // One byte-level command towards the I2C core.
    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic [7:0] data;
    } i2c_cmd_t;

    // One byte-level response from the I2C core.
    typedef struct packed {
        logic [7:0] data;
        logic       nack;
    } i2c_rsp_t;

    // Arbiter bus-ownership states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/rv_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr, with wrap.
module rv_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] index
);
    localparam int IW = $clog2(NUM_REQ);

    // Doubling the vector lets a plain slice from ptr implement the wrap.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    assign req_dbl = {req, req};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign req_rot[gi] = req_dbl[int'(ptr) + gi];
        end
    endgenerate

    // Lowest rotated offset wins; map it back to an absolute requester index.
    always_comb begin
        int off;
        int sum;
        found = 1'b0;
        off   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        index = IW'(sum);
    end

endmodule

// File: rtl/rv_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C command/response channel between requesters.
// Ownership lasts a whole bus transaction; a stalled owner gets a stop injected.
module rv_i2c_arbiter
    import rv_i2c_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter logic [15:0] HOLD_TIMEOUT = 16'd1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_start,
    input  logic [NUM_REQ-1:0]         req_stop,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_nack,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_start,
    output logic                       cmd_stop,
    output logic                       cmd_read,
    output logic [7:0]                 cmd_data,
    input  logic                       i2c_rsp_valid,
    output logic                       i2c_rsp_ready,
    input  logic [7:0]                 i2c_rsp_data,
    input  logic                       i2c_rsp_nack,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_t    state_reg,  state_next;
    i2c_cmd_t      cmd_reg,    cmd_next;
    logic [IW-1:0] owner_reg,  owner_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [15:0]   cnt_reg,    cnt_next;
    logic          inject_reg, inject_next;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [7:0]    req_byte [NUM_REQ];
    i2c_rsp_t      core_rsp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rv_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .index (pick_idx)
    );

    // Responses are broadcast; only rsp_valid steers them to the owner.
    assign core_rsp  = '{data: i2c_rsp_data, nack: i2c_rsp_nack};
    assign rsp_data  = core_rsp.data;
    assign rsp_nack  = core_rsp.nack;
    assign cmd_valid = (state_reg == ISSUE);
    assign cmd_start = cmd_reg.start;
    assign cmd_stop  = cmd_reg.stop;
    assign cmd_read  = cmd_reg.read;
    assign cmd_data  = cmd_reg.data;
    assign owner     = owner_reg;
    assign busy      = (state_reg != IDLE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cmd_reg    <= '0;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
            inject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cmd_reg    <= cmd_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            inject_reg <= inject_next;
        end
    end

    // Next-state logic, handshakes and response routing.
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        cnt_next      = cnt_reg;
        inject_next   = inject_reg;
        req_ready     = '0;
        rsp_valid     = '0;
        i2c_rsp_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    req_ready[pick_idx] = 1'b1;
                    cmd_next.start = 1'b1;
                    cmd_next.stop  = req_stop[pick_idx];
                    cmd_next.read  = req_read[pick_idx];
                    cmd_next.data  = req_byte[pick_idx];
                    owner_next     = pick_idx;
                    rr_ptr_next    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (inject_reg) begin
                    // The injected stop belongs to nobody: swallow its response.
                    i2c_rsp_ready = 1'b1;
                    if (i2c_rsp_valid) begin
                        inject_next = 1'b0;
                        state_next  = IDLE;
                    end
                end else begin
                    rsp_valid[owner_reg] = i2c_rsp_valid;
                    i2c_rsp_ready        = rsp_ready[owner_reg];
                    if (i2c_rsp_valid && rsp_ready[owner_reg]) begin
                        if (cmd_reg.stop) begin
                            state_next = IDLE;
                        end else begin
                            state_next = HOLD;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (req_valid[owner_reg]) begin
                    // An owner request beats a timeout landing in the same cycle.
                    req_ready[owner_reg] = 1'b1;
                    cmd_next.start = req_start[owner_reg];
                    cmd_next.stop  = req_stop[owner_reg];
                    cmd_next.read  = req_read[owner_reg];
                    cmd_next.data  = req_byte[owner_reg];
                    state_next     = ISSUE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                    if ((HOLD_TIMEOUT != 16'd0) && (cnt_next == HOLD_TIMEOUT)) begin
                        cmd_next    = '{start: 1'b0, stop: 1'b1, read: 1'b0, data: 8'h00};
                        inject_next = 1'b1;
                        state_next  = ISSUE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_i2c_arbiter.sv
// Scoreboard bench for rv_i2c_arbiter: requester drivers, a core model and a monitor.
module tb_rv_i2c_arbiter;
    localparam int N  = 4;
    localparam int HT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_start, req_stop, req_read;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   rsp_valid, rsp_ready;
    logic [7:0]     rsp_data;
    logic           rsp_nack;
    logic           cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read;
    logic [7:0]     cmd_data;
    logic           i2c_rsp_valid, i2c_rsp_ready, i2c_rsp_nack;
    logic [7:0]     i2c_rsp_data;
    logic [1:0]     owner;
    logic           busy;

    always #5 clk = ~clk;

    rv_i2c_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(16'(HT))) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_start(req_start),
        .req_stop(req_stop), .req_read(req_read), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_data(cmd_data),
        .i2c_rsp_valid(i2c_rsp_valid), .i2c_rsp_ready(i2c_rsp_ready),
        .i2c_rsp_data(i2c_rsp_data), .i2c_rsp_nack(i2c_rsp_nack),
        .owner(owner), .busy(busy)
    );

    typedef struct {
        logic st; logic sp; logic rd; logic [7:0] d; int tag;
    } exp_cmd_t;
    typedef struct {
        int tag; logic [7:0] d; logic n;
    } exp_rsp_t;

    int checks = 0;
    int errors = 0;

    exp_cmd_t cmd_q[$];
    int       tag_q[$];
    exp_rsp_t rsp_q[$];
    int       grant_log[$];
    int       rsp_count[N];
    int       inject_seen = 0;

    // Reference model of bus ownership, expressed as the arbitration rules.
    bit m_free = 1'b1, m_outst = 1'b0, m_hold = 1'b0, m_last_stop = 1'b0;
    int m_owner = 0, m_ptr = 0, m_cnt = 0;

    // Stimulus knobs.
    bit         core_stall = 1'b0;
    bit         force_rsp  = 1'b0;
    logic [7:0] force_d    = 8'h00;
    logic       force_n    = 1'b0;
    logic [N-1:0] hold_low = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle against the model, then advances the model.
    initial begin
        logic [N-1:0] exp_rdy;
        int win;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_q.delete(); tag_q.delete(); rsp_q.delete();
                m_free = 1'b1; m_outst = 1'b0; m_hold = 1'b0; m_last_stop = 1'b0;
                m_owner = 0; m_ptr = 0; m_cnt = 0;
            end else begin
                chk("busy", 32'(busy), 32'(!m_free));
                if (!m_free) chk("owner", 32'(owner), 32'(m_owner));
                exp_rdy = '0;
                win = -1;
                if (m_free) begin
                    for (int k = 0; k < N; k++) begin
                        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                    end
                end else if (m_hold && !m_outst && req_valid[m_owner]) begin
                    win = m_owner;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (win >= 0) begin
                    cmd_q.push_back('{st: m_free ? 1'b1 : req_start[win], sp: req_stop[win],
                                      rd: req_read[win], d: req_data[8*win +: 8], tag: win});
                    if (m_free) begin
                        grant_log.push_back(win);
                        m_ptr = (win + 1) % N;
                    end
                    m_owner = win; m_free = 1'b0; m_hold = 1'b0; m_outst = 1'b1;
                    m_last_stop = req_stop[win];
                end else if (!m_free && m_hold) begin
                    m_cnt++;
                    if (m_cnt == HT) begin
                        cmd_q.push_back('{st: 1'b0, sp: 1'b1, rd: 1'b0, d: 8'h00, tag: -1});
                        m_hold = 1'b0; m_outst = 1'b1; m_last_stop = 1'b1;
                    end
                end
                if (cmd_valid) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", 32'(cmd_valid), 32'd0);
                    end else begin
                        chk("cmd_fields", {cmd_start, cmd_stop, cmd_read, cmd_data},
                            {cmd_q[0].st, cmd_q[0].sp, cmd_q[0].rd, cmd_q[0].d});
                        if (cmd_ready) begin
                            tag_q.push_back(cmd_q[0].tag);
                            void'(cmd_q.pop_front());
                        end
                    end
                end
                if (i2c_rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'(i2c_rsp_valid), 32'd0);
                    end else begin
                        if (rsp_q[0].tag < 0) begin
                            chk("inject_rsp_valid", 32'(rsp_valid), 32'd0);
                            chk("inject_rsp_ready", 32'(i2c_rsp_ready), 32'd1);
                        end else begin
                            chk("rsp_route", 32'(rsp_valid), 32'(1 << rsp_q[0].tag));
                            chk("rsp_fields", {rsp_data, rsp_nack}, {rsp_q[0].d, rsp_q[0].n});
                            chk("rsp_ready_path", 32'(i2c_rsp_ready), 32'(rsp_ready[rsp_q[0].tag]));
                        end
                        if (i2c_rsp_ready) begin
                            if (rsp_q[0].tag < 0) inject_seen++;
                            else rsp_count[rsp_q[0].tag]++;
                            void'(rsp_q.pop_front());
                            m_outst = 1'b0;
                            if (m_last_stop) m_free = 1'b1;
                            else begin m_hold = 1'b1; m_cnt = 0; end
                        end
                    end
                end else begin
                    chk("rsp_idle", 32'(rsp_valid), 32'd0);
                end
            end
        end
    end

    // Core model: one response per accepted command after a short random latency.
    initial begin
        bit c_hs, r_hs, pend;
        int dly;
        pend = 1'b0; dly = 0;
        i2c_rsp_valid = 1'b0; i2c_rsp_data = 8'h00; i2c_rsp_nack = 1'b0; cmd_ready = 1'b0;
        forever begin
            @(negedge clk);
            c_hs = cmd_valid && cmd_ready && !rst;
            r_hs = i2c_rsp_valid && i2c_rsp_ready;
            @(posedge clk); #1;
            if (rst) begin
                i2c_rsp_valid = 1'b0; pend = 1'b0; cmd_ready = 1'b0;
            end else begin
                if (r_hs) i2c_rsp_valid = 1'b0;
                if (c_hs) begin
                    pend = 1'b1; dly = $urandom_range(0, 3);
                end else if (pend) begin
                    if (dly == 0) begin
                        pend = 1'b0;
                        i2c_rsp_data = force_rsp ? force_d : 8'($urandom);
                        i2c_rsp_nack = force_rsp ? force_n : 1'($urandom);
                        i2c_rsp_valid = 1'b1;
                        if (tag_q.size() == 0) chk("core_tag", 32'd0, 32'd1);
                        else rsp_q.push_back('{tag: tag_q.pop_front(), d: i2c_rsp_data, n: i2c_rsp_nack});
                    end else begin
                        dly--;
                    end
                end
                cmd_ready = core_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Requester-side response acceptance, randomly throttled.
    initial begin
        rsp_ready = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) rsp_ready[i] = hold_low[i] ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_byte(input int r, input bit st, input bit sp, input bit rd, input logic [7:0] d);
        bit ok;
        @(posedge clk); #1;
        req_valid[r] = 1'b1; req_start[r] = st; req_stop[r] = sp; req_read[r] = rd;
        req_data[8*r +: 8] = d;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        if (!ok) chk("grant_timeout", 32'(r), 32'hFFFF);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (m_free && !m_outst && cmd_q.size() == 0 && rsp_q.size() == 0 && !busy) ok = 1'b1;
        end
        chk("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        grant_log.delete();
    endtask

    task automatic random_txns(input int r);
        int len;
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                send_byte(r, b == 0, (b == len - 1) && ($urandom_range(0, 3) != 0),
                          1'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
    endtask

    initial begin
        int base2, base1, inj0;
        bit ok;
        rst = 1'b1;
        req_valid = '0; req_start = '0; req_stop = '0; req_read = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_i2c_rsp_ready", 32'(i2c_rsp_ready), 32'd0);
        chk("rst_cmd_fields", {cmd_start, cmd_stop, cmd_read, cmd_data}, 32'd0);
        chk("rst_owner_busy", {owner, busy}, 32'd0);

        // Requester 2: three-byte write transaction.
        base2 = rsp_count[2];
        send_byte(2, 1'b1, 1'b0, 1'b0, 8'hA0);
        send_byte(2, 1'b0, 1'b0, 1'b0, 8'h10);
        send_byte(2, 1'b0, 1'b1, 1'b0, 8'h55);
        wait_idle();
        chk("req2_rsp_count", 32'(rsp_count[2] - base2), 32'd3);
        $display("txn: req2 three-byte write done");

        // Reset while a command sits in ISSUE.
        core_stall = 1'b1;
        send_byte(2, 1'b1, 1'b1, 1'b0, 8'h77);
        @(negedge clk);
        chk("issue_before_rst", 32'(cmd_valid), 32'd1);
        do_reset();
        @(negedge clk);
        chk("post_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("post_rst_busy_owner", {owner, busy}, 32'd0);
        core_stall = 1'b0;
        $display("txn: reset during ISSUE");

        // Round-robin: all four requesters, two single-byte transactions each.
        fork
            begin send_byte(0, 1, 1, 0, 8'h01); send_byte(0, 1, 1, 0, 8'h02); end
            begin send_byte(1, 1, 1, 0, 8'h11); send_byte(1, 1, 1, 1, 8'h12); end
            begin send_byte(2, 1, 1, 0, 8'h21); send_byte(2, 1, 1, 0, 8'h22); end
            begin send_byte(3, 1, 1, 1, 8'h31); send_byte(3, 1, 1, 0, 8'h32); end
        join
        wait_idle();
        chk("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % N));
        $display("txn: round-robin across four requesters");

        // Requester 1 holds the bus while requester 3 waits.
        grant_log.delete();
        fork
            begin
                send_byte(1, 1, 0, 0, 8'hB0);
                send_byte(1, 0, 0, 1, 8'hB1);
                send_byte(1, 0, 1, 0, 8'hB2);
            end
            begin
                ok = 1'b0;
                for (int k = 0; k < 200 && !ok; k++) begin
                    @(negedge clk);
                    if (!m_free && m_owner == 1) ok = 1'b1;
                end
                chk("req1_owns", 32'(ok), 32'd1);
                send_byte(3, 1, 1, 0, 8'hD3);
            end
        join
        wait_idle();
        chk("hold_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) chk("hold_order", {grant_log[0][15:0], grant_log[1][15:0]}, {16'd1, 16'd3});
        $display("txn: requester 3 waits for requester 1 stop");

        // Owner stalls in HOLD: a stop is injected and swallowed.
        inj0 = inject_seen; base1 = rsp_count[1];
        send_byte(1, 1, 0, 0, 8'h42);
        wait_idle();
        chk("inject_count", 32'(inject_seen - inj0), 32'd1);
        chk("inject_owner_rsp", 32'(rsp_count[1] - base1), 32'd1);
        $display("txn: hold timeout inject");

        // Read with NACK and a stalled requester response.
        force_rsp = 1'b1; force_d = 8'hC3; force_n = 1'b1; hold_low[0] = 1'b1;
        fork
            send_byte(0, 1, 1, 1, 8'h00);
            begin
                ok = 1'b0;
                for (int k = 0; k < 200 && !ok; k++) begin
                    @(negedge clk);
                    if (rsp_valid[0]) ok = 1'b1;
                end
                chk("nack_rsp_seen", 32'(ok), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    chk("nack_stall", {rsp_valid[0], i2c_rsp_ready, rsp_nack, rsp_data}, {1'b1, 1'b0, 1'b1, 8'hC3});
                    @(negedge clk);
                end
                hold_low[0] = 1'b0;
            end
        join
        wait_idle();
        force_rsp = 1'b0;
        $display("txn: read NACK with stalled response");

        // Randomized concurrent traffic.
        fork
            random_txns(0);
            random_txns(1);
            random_txns(2);
            random_txns(3);
        join
        wait_idle();
        $display("txn: random traffic, %0d injected stops total", inject_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
